// File: rtl/execute_stage.sv
// Execute stage between decode and memory access: RV32I ALU, address, link and
// branch-condition evaluation. Define RV32M_EN to build in the iterative multiply/divide unit.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic [31:0] instr_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] data_o,
    output logic [4:0]  sel_rd_o
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        is_mop;
    logic [31:0] op_b;
    logic [31:0] sra_res;
    logic [31:0] alu_res;
    logic        br_taken;
    logic [31:0] exec_res;
    logic        unused_rs1_field;

    logic [31:0] instr_q, instr_d;
    logic [31:0] result_q, result_d;
    logic [31:0] data_q, data_d;

    assign opcode           = instr_i[6:0];
    assign funct3           = instr_i[14:12];
    assign imm_i            = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s            = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u            = {instr_i[31:12], 12'b0};
    assign is_mop           = (opcode == OPC_OP) && (instr_i[31:25] == 7'b0000001);
    assign unused_rs1_field = ^instr_i[19:15];

    // Only register-register ops take rs2; for OP-IMM bit 30 is an immediate bit
    // except for SRAI, so SUB is gated on OP.
    assign op_b    = (opcode == OPC_OP) ? rs2_data_i : imm_i;
    assign sra_res = $signed(rs1_data_i) >>> op_b[4:0];

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = ((opcode == OPC_OP) && instr_i[30]) ? rs1_data_i - op_b
                                                                   : rs1_data_i + op_b;
            3'b001:  alu_res = rs1_data_i << op_b[4:0];
            3'b010:  alu_res = {31'b0, $signed(rs1_data_i) < $signed(op_b)};
            3'b011:  alu_res = {31'b0, rs1_data_i < op_b};
            3'b100:  alu_res = rs1_data_i ^ op_b;
            3'b101:  alu_res = instr_i[30] ? sra_res : (rs1_data_i >> op_b[4:0]);
            3'b110:  alu_res = rs1_data_i | op_b;
            default: alu_res = rs1_data_i & op_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_data_i == rs2_data_i);
            3'b001:  br_taken = (rs1_data_i != rs2_data_i);
            3'b100:  br_taken = ($signed(rs1_data_i) < $signed(rs2_data_i));
            3'b101:  br_taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            3'b110:  br_taken = (rs1_data_i < rs2_data_i);
            3'b111:  br_taken = (rs1_data_i >= rs2_data_i);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        exec_res = '0;
        case (opcode)
            OPC_OP:            exec_res = is_mop ? 32'd0 : alu_res;
            OPC_OP_IMM:        exec_res = alu_res;
            OPC_LOAD:          exec_res = rs1_data_i + imm_i;
            OPC_STORE:         exec_res = rs1_data_i + imm_s;
            OPC_LUI:           exec_res = imm_u;
            OPC_AUIPC:         exec_res = pc_i + imm_u;
            OPC_JAL, OPC_JALR: exec_res = pc_i + 32'd4;
            OPC_BRANCH:        exec_res = {31'b0, br_taken};
            default:           exec_res = '0;
        endcase
    end

`ifdef RV32M_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mc_q, mc_d;
    logic [2:0]  mfn_q, mfn_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;

    logic        a_signed_op;
    logic        a_sgn;
    logic        b_sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_trial;
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] m_result;
    logic        unused_trial_bit;

    assign a_signed_op      = !((funct3 == 3'b011) || (funct3 == 3'b101) || (funct3 == 3'b111));
    assign a_sgn            = a_signed_op && rs1_data_i[31];
    assign b_sgn            = a_signed_op && (funct3 != 3'b010) && rs2_data_i[31];
    assign a_mag            = a_sgn ? -rs1_data_i : rs1_data_i;
    assign b_mag            = b_sgn ? -rs2_data_i : rs2_data_i;
    assign mul_sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : 33'd0);
    assign div_shift        = {hi_q, lo_q[31]};
    assign div_trial        = {1'b0, div_shift} - {2'b00, mc_q};
    assign unused_trial_bit = div_trial[32];

    assign stall_o = ((state_q == S_IDLE) && is_mop) || (state_q == S_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mc_d    = mc_q;
        mfn_d   = mfn_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (is_mop) begin
                    // Multiply: lo holds the multiplier, mc the multiplicand.
                    // Divide: lo holds the dividend, mc the divisor.
                    state_d = S_BUSY;
                    cnt_d   = 5'd31;
                    hi_d    = '0;
                    lo_d    = funct3[2] ? a_mag : b_mag;
                    mc_d    = funct3[2] ? b_mag : a_mag;
                    mfn_d   = funct3;
                    neg_d   = (funct3[2] && funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
                    dz_d    = (rs2_data_i == 32'd0);
                end
            end
            S_BUSY: begin
                if (!mfn_q[2]) begin
                    hi_d = mul_sum[32:1];
                    lo_d = {mul_sum[0], lo_q[31:1]};
                end else if (!div_trial[33]) begin
                    hi_d = div_trial[31:0];
                    lo_d = {lo_q[30:0], 1'b1};
                end else begin
                    hi_d = div_shift[31:0];
                    lo_d = {lo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_DONE;
                    cnt_d   = 5'd0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign prod     = {hi_q, lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = dz_q ? 32'hFFFF_FFFF : (neg_q ? -lo_q : lo_q);
    assign rem_fix  = neg_q ? -hi_q : hi_q;

    always_comb begin
        m_result = '0;
        case (mfn_q)
            3'b000:         m_result = prod_fix[31:0];
            3'b100, 3'b101: m_result = quo_fix;
            3'b110, 3'b111: m_result = rem_fix;
            default:        m_result = prod_fix[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mc_q    <= '0;
            mfn_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mc_q    <= mc_d;
            mfn_q   <= mfn_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
        end
    end
`else
    assign stall_o = 1'b0;
`endif

    always_comb begin
        instr_d  = instr_i;
        result_d = exec_res;
        data_d   = rs2_data_i;
`ifdef RV32M_EN
        if (stall_o) begin
            instr_d  = '0;
            result_d = '0;
            data_d   = '0;
        end else if (state_q == S_DONE) begin
            result_d = m_result;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            result_q <= '0;
            data_q   <= '0;
        end else begin
            instr_q  <= instr_d;
            result_q <= result_d;
            data_q   <= data_d;
        end
    end

    assign instr_o      = instr_q;
    assign alu_result_o = result_q;
    assign data_o       = data_q;

    always_comb begin
        sel_rd_o = '0;
        case (instr_q[6:0])
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: sel_rd_o = instr_q[11:7];
            default:                      sel_rd_o = '0;
        endcase
    end
endmodule
